reservation_station: RTL and testbench
======================================

// Module: reservation_station
// PURPOSE
//  Out-of-order issue queue of the Tomasulo core: holds dispatched ALU/branch/jump ops until both operands are ready.
//  Drives the execute unit's iRS_* port and snoops the EX and SLB result broadcasts (CDB) for operand wakeup.
//  Emits one ready op per cycle. Flushed by the ROB on mispredict.
// PARAMETERS
//  RS_SIZE   16  number of entries
//  RS_IDX_W  4   log2(RS_SIZE); entry index width
// PORTS
//  clk            in   1        clock
//  rst            in   1        synchronous active-high reset
//  rdy            in   1        global enable; low = freeze all state
//  iROB_clr       in   1        flush all entries (mispredict)
//  iDP_en         in   1        dispatch valid
//  iDP_pc/op/imm  in   `AddrBus/`OpBus/`ImmBus  instruction fields
//  iDP_rd_nick    in   `NickBus ROB tag of destination
//  iDP_rs1_rdy    in   1        rs1 value valid; else wait on iDP_rs1_nick
//  iDP_rs1_dt     in   `DataBus rs1 value
//  iDP_rs1_nick   in   `NickBus rs1 producer tag
//  iDP_rs2_rdy/dt/nick  in  1/`DataBus/`NickBus  as rs1
//  iEX_en/nick/dt   in 1/`NickBus/`DataBus  ALU result broadcast
//  iSLB_en/nick/dt  in 1/`NickBus/`DataBus  load result broadcast
//  oRS_full       out  1        registered; dispatcher must not assert iDP_en while high
//  oRS_en         out  1        issue valid to execute (one-cycle pulse per op)
//  oRS_pc/op/imm/rd_nick/rs1_dt/rs2_dt  out  as iDP_*  issued op
// BEHAVIOUR
//  - Reset: all busy=0; oRS_en=0, oRS_full=0, all other outputs 0. rst has priority over rdy and iROB_clr.
//  - rdy=0: no state or output changes; CDB inputs ignored (producers are frozen too).
//  - iROB_clr (rdy=1): all busy<=0, oRS_en<=0, oRS_full<=0; same-cycle iDP_en ignored.
//  - Entry: busy, pc, op, imm, rd_nick, {Vj,Qj,Rj}, {Vk,Qk,Rk}.
//  - Dispatch: iDP_en writes lowest-index non-busy entry (busy snapshot at cycle start).
//    Operand with rdy=0 whose nick matches a same-cycle iEX/iSLB broadcast is captured ready at dispatch.
//  - Wakeup: each busy, not-ready operand with Q==broadcast nick latches dt and sets R; both CDBs checked
//    every cycle; rs1 and rs2 may wake on the same broadcast. EX and SLB never carry the same nick.
//  - Select: lowest-index busy entry with Rj&Rk (state at cycle start). Outputs registered: issued fields
//    appear with oRS_en=1 after the edge; entry busy<=0 on that edge. No ready entry -> oRS_en<=0.
//  - Latency: dispatch with both operands ready at edge N -> oRS_en high after edge N+1.
//  - Freed entry is not reallocated in the cycle it issues; dispatch and issue may occur the same cycle.
//  - oRS_full <= (next-cycle occupancy >= RS_SIZE-1), leaving one slot for the dispatcher's registered lag.
//  - Occupancy counter: +1 on dispatch, -1 on issue, both -> unchanged; never wraps.
//  - Ops only ALU/branch/jump; no opcode decode inside; op passes through unmodified.
// CONFIGURATION
//  RS_WAKEUP_ISSUE_EN defined: entry whose last missing operand arrives on CDB in cycle N is eligible
//    for select in cycle N; CDB dt is forwarded straight into the issue mux (saves 1 cycle).
//  Undefined: wakeup latches at edge N; entry eligible from cycle N+1. Select uses only stored state.
// STRUCTURE
//  config.v (shared): `DataBus/`AddrBus/`ImmBus/`OpBus/`NickBus widths, opcode constants, RS_SIZE default.
//  Sub-module rs_pick: combinational lowest-index priority encoder, instanced twice
//    (free-slot find for dispatch, ready-entry find for issue); outputs found flag + index.
// TESTING
//  1 Dispatch ADD rs1=5,rs2=7 both ready, nick=3 at cycle 0 -> cycle 1 oRS_en=1, op=ADD, dt 5/7, rd_nick=3.
//  2 Dispatch rs1 waiting on nick 6; 3 cycles later iEX_en nick=6 dt=0x10 -> oRS_en with rs1_dt=0x10
//    one cycle after broadcast (same cycle's select if RS_WAKEUP_ISSUE_EN).
//  3 Dispatch rs2 waiting nick 9 while iSLB_en nick=9 dt=0xAB same cycle -> issues next cycle, rs2_dt=0xAB.
//  4 Entries 2 and 5 become ready together -> entry 2 issues, entry 5 on the following cycle.
//  5 Dispatch 15 never-ready ops -> oRS_full=1 after 15th; issue one -> oRS_full=0 next cycle.
//  6 4 busy, iROB_clr=1 with iDP_en=1 -> next cycle oRS_en=0, oRS_full=0, no later issue of old/new ops;
//    rdy=0 for 3 cycles mid-stream -> outputs held bit-exact.

Source files
------------

// File: rtl/reservation_station_pkg.sv
// rtl/reservation_station_pkg.sv - shared widths, opcodes, entry layout and CDB match helpers
// Bus widths double as the core-wide config; RS_SIZE is the default depth.
package reservation_station_pkg;

    localparam int RS_SIZE  = 16;
    localparam int RS_IDX_W = 4;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int IMM_W  = 32;
    localparam int OP_W   = 6;
    localparam int NICK_W = 4;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [IMM_W-1:0]  imm_t;
    typedef logic [OP_W-1:0]   op_t;
    typedef logic [NICK_W-1:0] nick_t;

    localparam op_t OP_ADD  = 6'h01;
    localparam op_t OP_SUB  = 6'h02;
    localparam op_t OP_AND  = 6'h03;
    localparam op_t OP_OR   = 6'h04;
    localparam op_t OP_BEQ  = 6'h10;
    localparam op_t OP_BNE  = 6'h11;
    localparam op_t OP_JAL  = 6'h20;
    localparam op_t OP_JALR = 6'h21;

    typedef struct packed {
        logic  busy;
        addr_t pc;
        op_t   op;
        imm_t  imm;
        nick_t rd_nick;
        data_t vj;
        nick_t qj;
        logic  rj;
        data_t vk;
        nick_t qk;
        logic  rk;
    } rs_entry_t;

    // EX and SLB never carry the same nick, so EX-first ordering is only a tie-break on paper.
    function automatic logic cdb_hit(logic ex_en, nick_t ex_nick, logic slb_en, nick_t slb_nick,
                                     nick_t q);
        return (ex_en && ex_nick == q) || (slb_en && slb_nick == q);
    endfunction

    function automatic data_t cdb_val(logic ex_en, nick_t ex_nick, data_t ex_dt, data_t slb_dt,
                                      nick_t q);
        return (ex_en && ex_nick == q) ? ex_dt : slb_dt;
    endfunction

endpackage

// File: rtl/reservation_station_if.sv
// rtl/reservation_station_if.sv - dispatch, CDB snoop and issue bundle of the reservation station
// slave is the station side; master is the dispatcher/CDB/execute environment.
interface reservation_station_if;
    import reservation_station_pkg::*;

    logic  rdy;
    logic  iROB_clr;

    logic  iDP_en;
    addr_t iDP_pc;
    op_t   iDP_op;
    imm_t  iDP_imm;
    nick_t iDP_rd_nick;
    logic  iDP_rs1_rdy;
    data_t iDP_rs1_dt;
    nick_t iDP_rs1_nick;
    logic  iDP_rs2_rdy;
    data_t iDP_rs2_dt;
    nick_t iDP_rs2_nick;

    logic  iEX_en;
    nick_t iEX_nick;
    data_t iEX_dt;
    logic  iSLB_en;
    nick_t iSLB_nick;
    data_t iSLB_dt;

    logic  oRS_full;
    logic  oRS_en;
    addr_t oRS_pc;
    op_t   oRS_op;
    imm_t  oRS_imm;
    nick_t oRS_rd_nick;
    data_t oRS_rs1_dt;
    data_t oRS_rs2_dt;

    modport slave (
        input  rdy, iROB_clr,
        input  iDP_en, iDP_pc, iDP_op, iDP_imm, iDP_rd_nick,
        input  iDP_rs1_rdy, iDP_rs1_dt, iDP_rs1_nick, iDP_rs2_rdy, iDP_rs2_dt, iDP_rs2_nick,
        input  iEX_en, iEX_nick, iEX_dt, iSLB_en, iSLB_nick, iSLB_dt,
        output oRS_full, oRS_en, oRS_pc, oRS_op, oRS_imm, oRS_rd_nick, oRS_rs1_dt, oRS_rs2_dt
    );

    modport master (
        output rdy, iROB_clr,
        output iDP_en, iDP_pc, iDP_op, iDP_imm, iDP_rd_nick,
        output iDP_rs1_rdy, iDP_rs1_dt, iDP_rs1_nick, iDP_rs2_rdy, iDP_rs2_dt, iDP_rs2_nick,
        output iEX_en, iEX_nick, iEX_dt, iSLB_en, iSLB_nick, iSLB_dt,
        input  oRS_full, oRS_en, oRS_pc, oRS_op, oRS_imm, oRS_rd_nick, oRS_rs1_dt, oRS_rs2_dt
    );

endinterface

// File: rtl/reservation_station_rs_pick.sv
// rtl/reservation_station_rs_pick.sv - lowest-index priority encoder over the station entries
// Used for both the free-slot search and the ready-entry search.
module rs_pick
    import reservation_station_pkg::*;
(
    input  logic [RS_SIZE-1:0]  req,
    output logic                found,
    output logic [RS_IDX_W-1:0] idx
);

    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (req[i]) begin
                found = 1'b1;
                idx   = RS_IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/reservation_station.sv
// rtl/reservation_station.sv - Tomasulo ALU/branch issue queue with CDB wakeup, one issue per cycle
// RS_WAKEUP_ISSUE_EN: let an operand arriving on the CDB make its entry selectable in the same cycle.
module reservation_station
    import reservation_station_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    reservation_station_if.slave rs
);

    localparam logic [RS_IDX_W:0] OCC_ONE   = (RS_IDX_W + 1)'(1);
    localparam logic [RS_IDX_W:0] FULL_MARK = (RS_IDX_W + 1)'(RS_SIZE - 1);

    rs_entry_t           ent [RS_SIZE];
    logic [RS_SIZE-1:0]  free_v;
    logic [RS_SIZE-1:0]  ready_v;
    logic [RS_SIZE-1:0]  wake_j;
    logic [RS_SIZE-1:0]  wake_k;
    data_t               wake_j_dt [RS_SIZE];
    data_t               wake_k_dt [RS_SIZE];

    logic                free_found;
    logic                sel_found;
    logic [RS_IDX_W-1:0] free_idx;
    logic [RS_IDX_W-1:0] sel_idx;
    logic                do_disp;
    logic [RS_IDX_W:0]   occ;
    logic [RS_IDX_W:0]   occ_next;
    data_t               sel_j;
    data_t               sel_k;
    rs_entry_t           disp_ent;

    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            free_v[i]    = !ent[i].busy;
            wake_j[i]    = ent[i].busy && !ent[i].rj &&
                           cdb_hit(rs.iEX_en, rs.iEX_nick, rs.iSLB_en, rs.iSLB_nick, ent[i].qj);
            wake_k[i]    = ent[i].busy && !ent[i].rk &&
                           cdb_hit(rs.iEX_en, rs.iEX_nick, rs.iSLB_en, rs.iSLB_nick, ent[i].qk);
            wake_j_dt[i] = cdb_val(rs.iEX_en, rs.iEX_nick, rs.iEX_dt, rs.iSLB_dt, ent[i].qj);
            wake_k_dt[i] = cdb_val(rs.iEX_en, rs.iEX_nick, rs.iEX_dt, rs.iSLB_dt, ent[i].qk);
`ifdef RS_WAKEUP_ISSUE_EN
            ready_v[i]   = ent[i].busy && (ent[i].rj || wake_j[i]) && (ent[i].rk || wake_k[i]);
`else
            ready_v[i]   = ent[i].busy && ent[i].rj && ent[i].rk;
`endif
        end
    end

    rs_pick u_free_pick (.req(free_v),  .found(free_found), .idx(free_idx));
    rs_pick u_sel_pick  (.req(ready_v), .found(sel_found),  .idx(sel_idx));

    always_comb begin
        sel_j = ent[sel_idx].vj;
        sel_k = ent[sel_idx].vk;
`ifdef RS_WAKEUP_ISSUE_EN
        if (!ent[sel_idx].rj) sel_j = wake_j_dt[sel_idx];
        if (!ent[sel_idx].rk) sel_k = wake_k_dt[sel_idx];
`endif
    end

    // An operand whose producer broadcasts in the dispatch cycle would otherwise miss its wakeup.
    always_comb begin
        disp_ent         = '0;
        disp_ent.busy    = 1'b1;
        disp_ent.pc      = rs.iDP_pc;
        disp_ent.op      = rs.iDP_op;
        disp_ent.imm     = rs.iDP_imm;
        disp_ent.rd_nick = rs.iDP_rd_nick;
        disp_ent.qj      = rs.iDP_rs1_nick;
        disp_ent.rj      = rs.iDP_rs1_rdy ||
                           cdb_hit(rs.iEX_en, rs.iEX_nick, rs.iSLB_en, rs.iSLB_nick, rs.iDP_rs1_nick);
        disp_ent.vj      = rs.iDP_rs1_rdy ? rs.iDP_rs1_dt :
                           cdb_val(rs.iEX_en, rs.iEX_nick, rs.iEX_dt, rs.iSLB_dt, rs.iDP_rs1_nick);
        disp_ent.qk      = rs.iDP_rs2_nick;
        disp_ent.rk      = rs.iDP_rs2_rdy ||
                           cdb_hit(rs.iEX_en, rs.iEX_nick, rs.iSLB_en, rs.iSLB_nick, rs.iDP_rs2_nick);
        disp_ent.vk      = rs.iDP_rs2_rdy ? rs.iDP_rs2_dt :
                           cdb_val(rs.iEX_en, rs.iEX_nick, rs.iEX_dt, rs.iSLB_dt, rs.iDP_rs2_nick);
    end

    assign do_disp = rs.iDP_en && free_found;

    always_comb begin
        occ_next = occ;
        if (do_disp && !sel_found)      occ_next = occ + OCC_ONE;
        else if (!do_disp && sel_found) occ_next = occ - OCC_ONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RS_SIZE; i++) ent[i].busy <= 1'b0;
            occ            <= '0;
            rs.oRS_full    <= 1'b0;
            rs.oRS_en      <= 1'b0;
            rs.oRS_pc      <= '0;
            rs.oRS_op      <= '0;
            rs.oRS_imm     <= '0;
            rs.oRS_rd_nick <= '0;
            rs.oRS_rs1_dt  <= '0;
            rs.oRS_rs2_dt  <= '0;
        end else if (rs.rdy) begin
            if (rs.iROB_clr) begin
                for (int i = 0; i < RS_SIZE; i++) ent[i].busy <= 1'b0;
                occ         <= '0;
                rs.oRS_full <= 1'b0;
                rs.oRS_en   <= 1'b0;
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (wake_j[i]) begin
                        ent[i].vj <= wake_j_dt[i];
                        ent[i].rj <= 1'b1;
                    end
                    if (wake_k[i]) begin
                        ent[i].vk <= wake_k_dt[i];
                        ent[i].rk <= 1'b1;
                    end
                end
                rs.oRS_en <= sel_found;
                if (sel_found) begin
                    ent[sel_idx].busy <= 1'b0;
                    rs.oRS_pc         <= ent[sel_idx].pc;
                    rs.oRS_op         <= ent[sel_idx].op;
                    rs.oRS_imm        <= ent[sel_idx].imm;
                    rs.oRS_rd_nick    <= ent[sel_idx].rd_nick;
                    rs.oRS_rs1_dt     <= sel_j;
                    rs.oRS_rs2_dt     <= sel_k;
                end
                // free_idx comes from the start-of-cycle snapshot, so it never aliases sel_idx.
                if (do_disp) ent[free_idx] <= disp_ent;
                occ         <= occ_next;
                rs.oRS_full <= (occ_next >= FULL_MARK);
            end
        end
    end

endmodule

// File: tb/tb_reservation_station.sv
// tb/tb_reservation_station.sv - directed and randomized bench for reservation_station with a queue-level model
module tb_reservation_station;
    import reservation_station_pkg::*;

`ifdef RS_WAKEUP_ISSUE_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    reservation_station_if rif ();
    reservation_station dut (.clk(clk), .rst(rst), .rs(rif.slave));

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a table of waiting ops, each operand either a value or a pending tag.
    bit    m_busy [RS_SIZE];
    addr_t m_pc   [RS_SIZE];
    op_t   m_op   [RS_SIZE];
    imm_t  m_imm  [RS_SIZE];
    nick_t m_rd   [RS_SIZE];
    data_t m_v    [RS_SIZE][2];
    nick_t m_q    [RS_SIZE][2];
    bit    m_r    [RS_SIZE][2];
    int    m_cnt;
    bit    e_en, e_full;
    addr_t e_pc;
    op_t   e_op;
    imm_t  e_imm;
    nick_t e_rd;
    data_t e_d [2];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit cdb_has(input nick_t q, output data_t d);
        d = '0;
        if (rif.iEX_en && rif.iEX_nick == q) begin d = rif.iEX_dt; return 1'b1; end
        if (rif.iSLB_en && rif.iSLB_nick == q) begin d = rif.iSLB_dt; return 1'b1; end
        return 1'b0;
    endfunction

    function automatic bit op_ready(input int i, input int k);
        data_t d;
        if (m_r[i][k]) return 1'b1;
        return FWD && cdb_has(m_q[i][k], d);
    endfunction

    function automatic data_t op_val(input int i, input int k);
        data_t d;
        if (m_r[i][k]) return m_v[i][k];
        void'(cdb_has(m_q[i][k], d));
        return d;
    endfunction

    task automatic model_step();
        int sel, free;
        data_t d;
        bit disp;
        if (rst) begin
            foreach (m_busy[i]) m_busy[i] = 1'b0;
            m_cnt = 0; e_en = 0; e_full = 0;
            e_pc = '0; e_op = '0; e_imm = '0; e_rd = '0; e_d[0] = '0; e_d[1] = '0;
            return;
        end
        if (!rif.rdy) return;
        if (rif.iROB_clr) begin
            foreach (m_busy[i]) m_busy[i] = 1'b0;
            m_cnt = 0; e_en = 0; e_full = 0;
            return;
        end
        sel = -1; free = -1;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (free < 0 && !m_busy[i]) free = i;
            if (sel < 0 && m_busy[i] && op_ready(i, 0) && op_ready(i, 1)) sel = i;
        end
        e_en = (sel >= 0);
        if (sel >= 0) begin
            e_pc = m_pc[sel]; e_op = m_op[sel]; e_imm = m_imm[sel]; e_rd = m_rd[sel];
            e_d[0] = op_val(sel, 0); e_d[1] = op_val(sel, 1);
        end
        for (int i = 0; i < RS_SIZE; i++)
            for (int k = 0; k < 2; k++)
                if (m_busy[i] && !m_r[i][k] && cdb_has(m_q[i][k], d)) begin
                    m_v[i][k] = d; m_r[i][k] = 1'b1;
                end
        if (sel >= 0) m_busy[sel] = 1'b0;
        disp = rif.iDP_en && (free >= 0);
        if (disp) begin
            m_busy[free] = 1'b1; m_pc[free] = rif.iDP_pc; m_op[free] = rif.iDP_op;
            m_imm[free] = rif.iDP_imm; m_rd[free] = rif.iDP_rd_nick;
            m_q[free][0] = rif.iDP_rs1_nick; m_q[free][1] = rif.iDP_rs2_nick;
            m_r[free][0] = rif.iDP_rs1_rdy;  m_r[free][1] = rif.iDP_rs2_rdy;
            m_v[free][0] = rif.iDP_rs1_dt;   m_v[free][1] = rif.iDP_rs2_dt;
            for (int k = 0; k < 2; k++)
                if (!m_r[free][k] && cdb_has(m_q[free][k], d)) begin
                    m_v[free][k] = d; m_r[free][k] = 1'b1;
                end
        end
        m_cnt = m_cnt + int'(disp) - int'(sel >= 0);
        e_full = (m_cnt >= RS_SIZE - 1);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("en", rif.oRS_en, e_en);
        chk("full", rif.oRS_full, e_full);
        chk("pc", rif.oRS_pc, e_pc);
        chk("op", rif.oRS_op, e_op);
        chk("imm", rif.oRS_imm, e_imm);
        chk("rd_nick", rif.oRS_rd_nick, e_rd);
        chk("rs1_dt", rif.oRS_rs1_dt, e_d[0]);
        chk("rs2_dt", rif.oRS_rs2_dt, e_d[1]);
    endtask

    task automatic idle();
        rif.iDP_en = 0; rif.iEX_en = 0; rif.iSLB_en = 0; rif.iROB_clr = 0; rif.rdy = 1;
    endtask

    task automatic dispatch(input op_t op, input nick_t rd, input bit r1, input data_t d1,
                            input nick_t n1, input bit r2, input data_t d2, input nick_t n2);
        rif.iDP_en = 1; rif.iDP_op = op; rif.iDP_rd_nick = rd;
        rif.iDP_pc = $urandom; rif.iDP_imm = $urandom;
        rif.iDP_rs1_rdy = r1; rif.iDP_rs1_dt = d1; rif.iDP_rs1_nick = n1;
        rif.iDP_rs2_rdy = r2; rif.iDP_rs2_dt = d2; rif.iDP_rs2_nick = n2;
    endtask

    task automatic ex_bcast(input nick_t n, input data_t d);
        rif.iEX_en = 1; rif.iEX_nick = n; rif.iEX_dt = d;
    endtask

    task automatic run_until_issue(input string tag);
        int n = 0;
        while (!rif.oRS_en && n < 8) begin tick(); n++; end
        chk(tag, rif.oRS_en, 1);
    endtask

    initial begin
        rst = 1; idle();
        dispatch(OP_ADD, 0, 0, 0, 0, 0, 0, 0); rif.iDP_en = 0;
        rif.iEX_nick = 0; rif.iEX_dt = 0; rif.iSLB_nick = 0; rif.iSLB_dt = 0;
        tick(); tick();
        chk("reset_en", rif.oRS_en, 0);
        chk("reset_full", rif.oRS_full, 0);
        rst = 0;

        // 1: both operands ready
        dispatch(OP_ADD, 3, 1, 5, 0, 1, 7, 0); tick(); idle();
        chk("t1_lat0", rif.oRS_en, 0);
        tick();
        chk("t1_en", rif.oRS_en, 1); chk("t1_op", rif.oRS_op, OP_ADD);
        chk("t1_rs1", rif.oRS_rs1_dt, 5); chk("t1_rs2", rif.oRS_rs2_dt, 7);
        chk("t1_rd", rif.oRS_rd_nick, 3);

        // 2: rs1 woken by EX three cycles after dispatch
        dispatch(OP_SUB, 4, 0, 0, 6, 1, 2, 0); tick(); idle();
        repeat (3) tick();
        ex_bcast(6, 32'h10); tick(); idle();
`ifdef RS_WAKEUP_ISSUE_EN
        chk("t2_en", rif.oRS_en, 1);
`else
        chk("t2_early", rif.oRS_en, 0);
        tick();
        chk("t2_en", rif.oRS_en, 1);
`endif
        chk("t2_rs1", rif.oRS_rs1_dt, 32'h10);

        // 3: rs2 captured from SLB in the dispatch cycle
        dispatch(OP_BEQ, 5, 1, 1, 0, 0, 0, 9);
        rif.iSLB_en = 1; rif.iSLB_nick = 9; rif.iSLB_dt = 32'hAB;
        tick(); idle(); tick();
        chk("t3_en", rif.oRS_en, 1); chk("t3_rs2", rif.oRS_rs2_dt, 32'hAB);

        // 4: entries 2 and 5 woken by the same broadcast
        for (int i = 0; i < 6; i++) begin
            dispatch(OP_OR, nick_t'(i), 0, 0, (i == 2 || i == 5) ? nick_t'(7) : nick_t'(10 + i), 1, 3, 0);
            tick();
        end
        idle(); ex_bcast(7, 32'h77); tick(); idle();
        run_until_issue("t4_first");
        chk("t4_first_rd", rif.oRS_rd_nick, 2);
        tick();
        chk("t4_second", rif.oRS_en, 1); chk("t4_second_rd", rif.oRS_rd_nick, 5);
        rif.iROB_clr = 1; tick(); idle();

        // 5: fill to 15, then release one
        for (int i = 0; i < 15; i++) begin
            dispatch(OP_JAL, nick_t'(i), 0, 0, (i == 0) ? nick_t'(1) : nick_t'(2), 1, 0, 0);
            tick();
            if (i == 13) chk("t5_full14", rif.oRS_full, 0);
        end
        idle();
        chk("t5_full15", rif.oRS_full, 1);
        ex_bcast(1, 32'h55); tick(); idle();
        run_until_issue("t5_issue");
        chk("t5_full_drop", rif.oRS_full, 0);
        rif.iROB_clr = 1; tick(); idle();

        // 6: flush with same-cycle dispatch, then a rdy freeze mid-stream
        for (int i = 0; i < 4; i++) begin dispatch(OP_AND, nick_t'(i), 0, 0, 3, 1, 0, 0); tick(); end
        dispatch(OP_ADD, 9, 1, 1, 0, 1, 1, 0); rif.iROB_clr = 1; tick(); idle();
        chk("t6_clr_en", rif.oRS_en, 0); chk("t6_clr_full", rif.oRS_full, 0);
        ex_bcast(3, 32'h33); tick(); idle();
        for (int i = 0; i < 3; i++) begin tick(); chk("t6_no_issue", rif.oRS_en, 0); end
        for (int i = 0; i < 3; i++) begin dispatch(OP_BNE, nick_t'(i), 1, $urandom, 0, 1, $urandom, 0); tick(); end
        rif.rdy = 0; ex_bcast(3, 32'h99); rif.iDP_en = 1;
        repeat (3) tick();
        idle(); repeat (6) tick();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            idle();
            rst = ($urandom_range(499) == 0);
            rif.rdy = ($urandom_range(7) != 0);
            rif.iROB_clr = ($urandom_range(99) == 0);
            if ((!e_full || (m_cnt < RS_SIZE && $urandom_range(3) == 0)) && $urandom_range(1) == 1)
                dispatch(op_t'($urandom_range(63)), nick_t'($urandom_range(15)),
                         bit'($urandom_range(1)), $urandom, nick_t'($urandom_range(7)),
                         bit'($urandom_range(1)), $urandom, nick_t'($urandom_range(7)));
            if ($urandom_range(2) == 0) ex_bcast(nick_t'($urandom_range(7)), $urandom);
            if ($urandom_range(2) == 0) begin
                rif.iSLB_en = 1; rif.iSLB_dt = $urandom;
                rif.iSLB_nick = nick_t'($urandom_range(7));
                if (rif.iEX_en && rif.iSLB_nick == rif.iEX_nick) rif.iSLB_nick = rif.iSLB_nick ^ 4'h8;
            end
            tick();
        end
        rst = 0; idle(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
